dmem_bridge: RTL and testbench

Data-memory bus bridge that sits directly downstream of the MEM stage. It takes the memory address, store data and access size produced by the load/store path. It runs one single-outstanding request/grant/response transaction on the data bus and returns the raw read word to the MEM stage's read-data input. While a transaction is in flight it holds the pipeline with `stall_o`, and it reports misaligned, illegal or failed accesses on `err_o`.

---
 rtl/dmem_pkg.sv | 43 ++++
 rtl/dmem_watchdog.sv | 34 +++
 rtl/dmem_bridge.sv | 206 ++++++++++++++++++++
 tb/tb_dmem_bridge.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the dmem_bridge data-memory bridge.
//   state_t        : bridge FSM states
//   SIZE_*         : access-size encodings of size_i
//   calc_be()      : byte enables for a size and byte offset
//   is_misaligned(): 1 when the size/offset pair cannot go on the bus
package dmem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_DATA  = 3'd2,
      ST_DONE  = 3'd3,
      ST_DRAIN = 3'd4
   } state_t;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] be;
      case (size)
         SIZE_B:  be = 4'b0001 << off;
         SIZE_H:  be = 4'b0011 << off;
         SIZE_W:  be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Size 11 is reported through the same path as a misaligned access.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      case (size)
         SIZE_B:  bad = 1'b0;
         SIZE_H:  bad = off[0];
         SIZE_W:  bad = (off != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_watchdog.sv
// dmem_watchdog: cycle counter that flags when a bus transaction has been
// in flight for LIMIT cycles.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : restart the count from zero
//   en_i         : count this cycle
//   timeout_o    : high while enabled and LIMIT cycles have been counted
module dmem_watchdog #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic timeout_o
);

   localparam logic [15:0] LIMIT_M1 = 16'(LIMIT - 1);

   logic [15:0] cnt_r;

   assign timeout_o = en_i && (cnt_r == LIMIT_M1);

   // Cycle counter; saturates once the limit is reached.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_r <= 16'd0;
      end else if (clr_i) begin
         cnt_r <= 16'd0;
      end else if (en_i && !timeout_o) begin
         cnt_r <= cnt_r + 16'd1;
      end
   end

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: single-outstanding request/grant/response bridge between the
// MEM stage and the data bus.
//   MEM side : req_i, we_i, size_i, addr_i, wdata_i, flush_i in;
//              rdata_o (last completed load), stall_o, err_o (DONE pulse) out
//   Bus side : bus_req_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o out;
//              bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i in
// Optional feature: define DMEM_TIMEOUT_EN to abort transactions after
// TIMEOUT_CYCLES cycles in ADDR/DATA and swallow the late response in DRAIN.
module dmem_bridge
   import dmem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [1:0]  size_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic        flush_i,
   output logic [31:0] rdata_o,
   output logic        stall_o,
   output logic        err_o,
   output logic        bus_req_o,
   input  logic        bus_gnt_i,
   output logic [31:0] bus_addr_o,
   output logic        bus_we_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_rvalid_i,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_err_i
);

   state_t      state_r, next_state_s;
   logic        accept_s, stall_s, to_take_s, resp_s, kill_now_s, misal_s;
   logic        timeout_s, drain_r;
   logic        err_flag_r, kill_r, bus_req_r, bus_we_r;
   logic [31:0] bus_addr_r, bus_wdata_r, rdata_r;
   logic [3:0]  bus_be_r;

   assign misal_s    = is_misaligned(size_i, addr_i[1:0]);
   // A flush arriving together with the response still kills it.
   assign kill_now_s = kill_r | flush_i;

   // Next-state decode and pipeline stall.
   always_comb begin
      next_state_s = state_r;
      accept_s     = 1'b0;
      stall_s      = 1'b0;
      to_take_s    = 1'b0;
      resp_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req_i && !flush_i) begin
               stall_s = 1'b1;
               if (drain_r && !bus_rvalid_i) begin
                  next_state_s = ST_DRAIN;
               end else begin
                  accept_s     = 1'b1;
                  next_state_s = misal_s ? ST_DONE : ST_ADDR;
               end
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_ADDR: begin
            stall_s = 1'b1;
            if (timeout_s) begin
               to_take_s    = 1'b1;
               next_state_s = ST_DONE;
            end else if (bus_gnt_i) begin
               next_state_s = ST_DATA;
            end else if (flush_i) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_ADDR;
            end
         end
         ST_DATA: begin
            stall_s = 1'b1;
            if (bus_rvalid_i) begin
               resp_s       = 1'b1;
               next_state_s = kill_now_s ? ST_IDLE : ST_DONE;
            end else if (timeout_s) begin
               to_take_s    = 1'b1;
               next_state_s = ST_DONE;
            end else begin
               next_state_s = ST_DATA;
            end
         end
         ST_DONE: begin
            next_state_s = ST_IDLE;
         end
         ST_DRAIN: begin
            stall_s = 1'b1;
            if (bus_rvalid_i || flush_i) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_DRAIN;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // FSM state and registered bus request (high exactly while in ADDR).
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r   <= ST_IDLE;
         bus_req_r <= 1'b0;
      end else begin
         state_r   <= next_state_s;
         bus_req_r <= (next_state_s == ST_ADDR);
      end
   end

   // Bus-side address/data registers, loaded on acceptance and held after.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bus_addr_r  <= 32'd0;
         bus_we_r    <= 1'b0;
         bus_be_r    <= 4'd0;
         bus_wdata_r <= 32'd0;
      end else if (accept_s) begin
         bus_addr_r  <= {addr_i[31:2], 2'b00};
         bus_we_r    <= we_i;
         bus_be_r    <= calc_be(size_i, addr_i[1:0]);
         bus_wdata_r <= wdata_i;
      end
   end

   // Error and kill flags of the transaction in flight.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_flag_r <= 1'b0;
         kill_r     <= 1'b0;
      end else if (accept_s) begin
         err_flag_r <= misal_s;
         kill_r     <= 1'b0;
      end else begin
         if (to_take_s || (resp_s && bus_err_i)) begin
            err_flag_r <= 1'b1;
         end
         // Grant beats a simultaneous flush in ADDR; the response is then killed.
         if (flush_i && ((state_r == ST_ADDR && bus_gnt_i) || state_r == ST_DATA)) begin
            kill_r <= 1'b1;
         end
      end
   end

   // Read-data register: updated only by completed loads, errors and timeouts.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_r <= 32'd0;
      end else if (resp_s && !kill_now_s && !bus_we_r) begin
         rdata_r <= bus_err_i ? 32'd0 : bus_rdata_i;
      end else if (to_take_s) begin
         rdata_r <= 32'd0;
      end
   end

`ifdef DMEM_TIMEOUT_EN
   logic wd_clr_s, wd_en_s;

   assign wd_clr_s = (next_state_s == ST_ADDR) && (state_r != ST_ADDR);
   assign wd_en_s  = (state_r == ST_ADDR) || (state_r == ST_DATA);

   dmem_watchdog #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (wd_clr_s),
      .en_i      (wd_en_s),
      .timeout_o (timeout_s)
   );

   // Drain flag: a granted transaction was abandoned and its response is still due.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         drain_r <= 1'b0;
      end else if (to_take_s && (state_r == ST_DATA || bus_gnt_i)) begin
         drain_r <= 1'b1;
      end else if (bus_rvalid_i && state_r != ST_ADDR && state_r != ST_DATA) begin
         drain_r <= 1'b0;
      end
   end
`else
   assign timeout_s = 1'b0;
   assign drain_r   = 1'b0;
`endif

   assign rdata_o     = rdata_r;
   assign stall_o     = stall_s;
   assign err_o       = (state_r == ST_DONE) && err_flag_r;
   assign bus_req_o   = bus_req_r;
   assign bus_addr_o  = bus_addr_r;
   assign bus_we_o    = bus_we_r;
   assign bus_be_o    = bus_be_r;
   assign bus_wdata_o = bus_wdata_r;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: self-checking bench for dmem_bridge. A reactive bus slave
// grants and responds after programmable delays; expected stall counts,
// bus fields, err_o and rdata_o come from a transaction-level model.
// With DMEM_TIMEOUT_EN defined, the timeout/drain behaviour is also exercised.
module tb_dmem_bridge;

   localparam int T = 8;
`ifdef DMEM_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_i = 1'b0;
   logic        we_i = 1'b0;
   logic [1:0]  size_i = 2'd0;
   logic [31:0] addr_i = 32'd0;
   logic [31:0] wdata_i = 32'd0;
   logic        flush_i = 1'b0;
   logic [31:0] rdata_o;
   logic        stall_o;
   logic        err_o;
   logic        bus_req_o;
   logic        bus_gnt_i = 1'b0;
   logic [31:0] bus_addr_o;
   logic        bus_we_o;
   logic [3:0]  bus_be_o;
   logic [31:0] bus_wdata_o;
   logic        bus_rvalid_i = 1'b0;
   logic [31:0] bus_rdata_i = 32'd0;
   logic        bus_err_i = 1'b0;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_rdata = 32'd0;

   dmem_bridge #(.TIMEOUT_CYCLES(T)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .flush_i(flush_i), .rdata_o(rdata_o),
      .stall_o(stall_o), .err_o(err_o), .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i),
      .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
      .bus_wdata_o(bus_wdata_o), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
      .bus_err_i(bus_err_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // One MEM-stage access. gd/rd: grant and response delays (rd<0: never).
   // fmode 0 none, 1 flush at ADDR cycle fat, 2 flush at DATA cycle fat.
   // late>=0: a stale response arrives at that cycle (drain scenario).
   task automatic run_access(input logic we, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd, input int gd, input int rd,
                             input logic [31:0] rdat, input logic berr,
                             input int fmode, input int fat, input int late);
      bit legal, to, aborted, eerr;
      bit granted, fl_done, finished, field_ok, early_err, early_req;
      int lane, tot, estall, ereq, stalls, reqs, req_seen, dcnt;
      logic [3:0]  ebe;
      logic        done_err;
      logic [31:0] done_rdata;

      lane  = int'(a[1:0]);
      legal = (sz == 2'd0) || (sz == 2'd1 && a[0] == 1'b0) || (sz == 2'd2 && a[1:0] == 2'd0);
      ebe   = (sz == 2'd0) ? 4'(1 << lane) : (sz == 2'd1) ? 4'(3 << lane) : 4'hF;
      tot   = (rd < 0) ? 1000 : gd + rd + 2;
      to    = legal && TO_EN && (tot > T);
      aborted = legal && !to && fmode == 1 && fat < gd;

      if (!legal) begin
         estall = 1; ereq = 0; eerr = 1'b1;
      end else if (to) begin
         estall = 1 + T; ereq = (gd + 1 < T) ? gd + 1 : T; eerr = 1'b1;
         m_rdata = 32'd0;
      end else if (aborted) begin
         estall = fat + 2; ereq = fat + 1; eerr = 1'b0;
      end else begin
         estall = gd + rd + 3; ereq = gd + 1;
         eerr = (fmode == 0) ? berr : 1'b0;
         if (fmode == 0 && !we) m_rdata = berr ? 32'd0 : rdat;
      end

      granted = 0; fl_done = 0; finished = 0; field_ok = 1; early_err = 0; early_req = 0;
      stalls = 0; reqs = 0; req_seen = 0; dcnt = 0;
      done_err = 1'b0; done_rdata = 32'd0;

      for (int cyc = 0; cyc <= 80 && !finished; cyc++) begin
         @(negedge clk_i);
         bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0; flush_i = 1'b0;
         bus_rdata_i = $urandom;
         if (cyc == 0) begin
            req_i = 1'b1; we_i = we; size_i = sz; addr_i = a; wdata_i = wd;
         end else begin
            if (late >= 0 && cyc <= late && bus_req_o) early_req = 1;
            if (late >= 0 && cyc == late) begin
               bus_rvalid_i = 1'b1;
            end else if (granted) begin
               if (rd >= 0 && dcnt == rd) begin
                  bus_rvalid_i = 1'b1; bus_rdata_i = rdat; bus_err_i = berr;
               end
               if (fmode == 2 && dcnt == fat && !fl_done) begin
                  flush_i = 1'b1; req_i = 1'b0; fl_done = 1;
               end
               dcnt++;
            end else if (bus_req_o) begin
               if (req_seen == gd) begin
                  bus_gnt_i = 1'b1; granted = 1;
               end
               if (fmode == 1 && req_seen == fat && !fl_done) begin
                  flush_i = 1'b1; req_i = 1'b0; fl_done = 1;
               end
               req_seen++;
            end
         end
         #1;
         if (stall_o) begin
            stalls++;
            if (err_o) early_err = 1;
         end else begin
            finished = 1; done_err = err_o; done_rdata = rdata_o;
         end
         if (bus_req_o) begin
            reqs++;
            if (bus_addr_o !== {a[31:2], 2'b00} || bus_be_o !== ebe || bus_we_o !== we ||
                (we && bus_wdata_o !== wd)) field_ok = 0;
         end
      end

      check("finished", 32'(finished), 32'd1);
      if (late < 0) check("stall_cycles", stalls, estall);
      if (late >= 0) check("drain_no_req", 32'(early_req), 32'd0);
      check("req_cycles", reqs, ereq);
      check("bus_fields", 32'(field_ok), 32'd1);
      check("err_in_stall", 32'(early_err), 32'd0);
      check("err_done", 32'(done_err), 32'(eerr));
      check("rdata", done_rdata, m_rdata);

      @(negedge clk_i);
      req_i = 1'b0; flush_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
      #1;
      check("err_pulse_end", 32'(err_o), 32'd0);
      check("idle_stall", 32'(stall_o), 32'd0);
   endtask

   initial begin
      logic        r_we, r_berr;
      logic [1:0]  r_sz;
      logic [31:0] r_a;
      int          r_gd, r_rd, r_fm, r_fat, r_sel;

      #12;
      check("rst_rdata", rdata_o, 32'd0);
      check("rst_stall", 32'(stall_o), 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
      check("rst_bus_req", 32'(bus_req_o), 32'd0);
      check("rst_bus_addr", bus_addr_o, 32'd0);
      check("rst_bus_we", 32'(bus_we_o), 32'd0);
      check("rst_bus_be", 32'(bus_be_o), 32'd0);
      check("rst_bus_wdata", bus_wdata_o, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;

      // Directed cases
      run_access(1'b0, 2'd1, 32'h0000_0201, 32'd0, 0, 0, 32'd0, 1'b0, 0, 0, -1);        // misaligned half
      run_access(1'b0, 2'd3, 32'h0000_0040, 32'd0, 0, 0, 32'd0, 1'b0, 0, 0, -1);        // illegal size
      run_access(1'b0, 2'd2, 32'h0000_0010, 32'd0, 1, 2, 32'h1111_2222, 1'b1, 0, 0, -1); // bus error
      run_access(1'b0, 2'd2, 32'h0000_0100, 32'd0, 0, 0, 32'hDEAD_BEEF, 1'b0, 0, 0, -1); // word load
      run_access(1'b1, 2'd0, 32'h0000_0103, 32'hAB00_0000, 4, 0, 32'd0, 1'b0, 0, 0, -1); // byte store
      run_access(1'b0, 2'd2, 32'h0000_0020, 32'd0, 3, 0, 32'h0BAD_0BAD, 1'b0, 1, 1, -1); // flush in ADDR
      run_access(1'b0, 2'd2, 32'h0000_0024, 32'd0, 0, 2, 32'h0BAD_0BAD, 1'b0, 2, 0, -1); // flush in DATA
      run_access(1'b0, 2'd1, 32'h0000_0032, 32'd0, 2, 1, 32'h0BAD_0BAD, 1'b0, 1, 2, -1); // grant+flush
      run_access(1'b0, 2'd1, 32'h0000_0036, 32'd0, 0, 0, 32'h0000_C0DE, 1'b0, 0, 0, -1); // half load

      // Reset in the middle of a transaction
      @(negedge clk_i);
      req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; addr_i = 32'h0000_0040;
      @(negedge clk_i);
      req_i = 1'b0; rst_i = 1'b1;
      #1;
      check("midrst_bus_req", 32'(bus_req_o), 32'd0);
      check("midrst_stall", 32'(stall_o), 32'd0);
      check("midrst_rdata", rdata_o, 32'd0);
      m_rdata = 32'd0;
      @(negedge clk_i);
      rst_i = 1'b0;

      // Randomized accesses
      for (int i = 0; i < 60; i++) begin
         r_we   = 1'($urandom_range(0, 1));
         r_sz   = 2'($urandom_range(0, 3));
         r_a    = $urandom;
         r_gd   = $urandom_range(0, 2);
         r_rd   = $urandom_range(0, 2);
         r_berr = !r_we && ($urandom_range(0, 5) == 0);
         r_sel  = $urandom_range(0, 5);
         r_fm   = (r_sel == 0) ? 1 : (r_sel == 1) ? 2 : 0;
         r_fat  = (r_fm == 1) ? $urandom_range(0, r_gd) : (r_fm == 2) ? $urandom_range(0, r_rd) : 0;
         run_access(r_we, r_sz, r_a, $urandom, r_gd, r_rd, $urandom, r_berr, r_fm, r_fat, -1);
      end

`ifdef DMEM_TIMEOUT_EN
      // Grant given, response withheld: abort after T cycles, then drain
      run_access(1'b0, 2'd2, 32'h0000_0300, 32'd0, 0, -1, 32'd0, 1'b0, 0, 0, -1);
      run_access(1'b0, 2'd2, 32'h0000_0304, 32'd0, 0, 0, 32'h1234_5678, 1'b0, 0, 0, 3);
      // Grant withheld: abort from ADDR, no drain afterwards
      run_access(1'b0, 2'd2, 32'h0000_0308, 32'd0, 20, 0, 32'd0, 1'b0, 0, 0, -1);
      run_access(1'b0, 2'd0, 32'h0000_0309, 32'd0, 0, 0, 32'h0000_5500, 1'b0, 0, 0, -1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
